if_fetch_ctrl: RTL and testbench

Instruction-fetch controller: the consumer of the program-counter register's output and the producer of its next-value and enable inputs. Each cycle it presents `PC_cur` to instruction memory over a req/ready handshake, computes `PCNext` (sequential +4 or execute-stage branch target) and the PC write enable, and loads the IF/ID pipeline register. It handles memory wait states, decode-stage stalls via a one-entry skid buffer, and branch redirects/flushes.

---
 rtl/if_fetch_ctrl_if.sv | 14 +
 rtl/if_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory fetch bus between the fetch controller and imem.
//   imem_req   : fetch request (controller -> memory)
//   imem_addr  : fetch address (controller -> memory)
//   imem_ready : memory accepted the request, rdata valid this cycle
//   imem_rdata : instruction word (memory -> controller)
interface if_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller.
// Presents PC_cur to instruction memory, produces PCNext/en for the PC
// register and loads the IF/ID register. Decode stalls that arrive with a
// returning word park that word in a one-entry skid buffer (HOLD state).
// Ports:
//   clk, reset (async, active low)
//   PC_cur            : current PC from the PC register
//   PCNext, en        : next PC and PC write enable (combinational)
//   imem              : fetch bus (master side)
//   stall_d           : decode-stage hold
//   PCSrcE, PCTargetE : execute-stage redirect
//   InstrD, PCD, PCPlus4D, validD : IF/ID register
//   fetch_count       : saturating count of delivered instructions
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            PC_cur,
  output logic [31:0]            PCNext,
  output logic                   en,
  if_fetch_ctrl_if.master        imem,
  input  logic                   stall_d,
  input  logic                   PCSrcE,
  input  logic [31:0]            PCTargetE,
  output logic [31:0]            InstrD,
  output logic [31:0]            PCD,
  output logic [31:0]            PCPlus4D,
  output logic                   validD,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] skid_q;
  logic [31:0] pc_plus4;

  // IF/ID update actions, mutually exclusive by construction
  logic flush, load_mem, load_skid, bubble, cap_skid;

  assign pc_plus4       = PC_cur + 32'd4;
  assign imem.imem_addr = PC_cur;

  always_comb begin
    state_nx      = state;
    imem.imem_req = 1'b0;
    en            = 1'b0;
    PCNext        = pc_plus4;
    flush         = 1'b0;
    load_mem      = 1'b0;
    load_skid     = 1'b0;
    bubble        = 1'b0;
    cap_skid      = 1'b0;
    unique case (state)
      BOOT: begin
        PCNext   = RESET_PC;
        state_nx = FETCH;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (PCSrcE) begin
          en     = 1'b1;
          PCNext = PCTargetE;
          flush  = 1'b1;
        end else if (imem.imem_ready && !stall_d) begin
          en       = 1'b1;
          load_mem = 1'b1;
        end else if (imem.imem_ready) begin
          cap_skid = 1'b1;
          state_nx = HOLD;
        end else if (!stall_d) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        // PC_cur still addresses the parked word, so no re-fetch
        if (PCSrcE) begin
          en       = 1'b1;
          PCNext   = PCTargetE;
          flush    = 1'b1;
          state_nx = FETCH;
        end else if (!stall_d) begin
          en        = 1'b1;
          load_skid = 1'b1;
          state_nx  = FETCH;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_q      <= NOP_INSTR;
      InstrD      <= NOP_INSTR;
      PCD         <= '0;
      PCPlus4D    <= '0;
      validD      <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (cap_skid) skid_q <= imem.imem_rdata;
      if (flush || bubble) begin
        InstrD <= NOP_INSTR;
        validD <= 1'b0;
      end else if (load_mem || load_skid) begin
        InstrD   <= load_mem ? imem.imem_rdata : skid_q;
        PCD      <= PC_cur;
        PCPlus4D <= pc_plus4;
        validD   <= 1'b1;
        if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_cur, PCNext, PCTargetE, InstrD, PCD, PCPlus4D, fetch_count;
  logic        en, stall_d, PCSrcE, validD;

  if_fetch_ctrl_if imem();

  if_fetch_ctrl dut (
    .clk(clk), .reset(reset), .PC_cur(PC_cur), .PCNext(PCNext), .en(en),
    .imem(imem.master), .stall_d(stall_d), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .validD(validD), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;
    logic        src;
    logic [31:0] tgt;
    // combinational expectations before the edge
    logic        e_en;
    logic [31:0] e_pcn;
    logic        e_req;
    // registered expectations after the edge
    logic [31:0] e_instr;
    logic [31:0] e_pcd;
    logic [31:0] e_p4;
    logic        e_v;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] pc, input logic rdy, input logic [31:0] rdata,
                     input logic stall, input logic src, input logic [31:0] tgt,
                     input logic e_en, input logic [31:0] e_pcn, input logic e_req,
                     input logic [31:0] e_instr, input logic [31:0] e_pcd,
                     input logic [31:0] e_p4, input logic e_v, input logic [31:0] e_cnt);
    vec_t v;
    v.pc = pc; v.rdy = rdy; v.rdata = rdata; v.stall = stall; v.src = src; v.tgt = tgt;
    v.e_en = e_en; v.e_pcn = e_pcn; v.e_req = e_req;
    v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_p4 = e_p4; v.e_v = e_v; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] pc, input logic rdy, input logic [31:0] rdata,
                       input logic stall, input logic src, input logic [31:0] tgt);
    PC_cur = pc; imem.imem_ready = rdy; imem.imem_rdata = rdata;
    stall_d = stall; PCSrcE = src; PCTargetE = tgt;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] p4, input logic v, input logic [31:0] c);
    chk({tag, " InstrD"}, InstrD, i);
    chk({tag, " PCD"}, PCD, p);
    chk({tag, " PCPlus4D"}, PCPlus4D, p4);
    chk({tag, " validD"}, {31'd0, validD}, {31'd0, v});
    chk({tag, " fetch_count"}, fetch_count, c);
  endtask

  initial begin
    //   pc            rdy rdata          st src tgt          en pcnext         req instrD         pcd            p4             v cnt
    add(32'h0,         1, 32'hDEAD_0000, 0, 0, 32'h0,       0, 32'h0,         0, NOP,           32'h0,         32'h0,         0, 0); // BOOT
    add(32'h0,         1, 32'hA000_0000, 0, 0, 32'h0,       1, 32'h4,         1, 32'hA000_0000, 32'h0,         32'h4,         1, 1);
    add(32'h4,         1, 32'hA000_0004, 0, 0, 32'h0,       1, 32'h8,         1, 32'hA000_0004, 32'h4,         32'h8,         1, 2);
    add(32'h8,         1, 32'hA000_0008, 0, 0, 32'h0,       1, 32'hC,         1, 32'hA000_0008, 32'h8,         32'hC,         1, 3);
    add(32'h10,        0, 32'hBAD0_0001, 0, 0, 32'h0,       0, 32'h14,        1, NOP,           32'h8,         32'hC,         0, 3); // wait 1
    add(32'h10,        0, 32'hBAD0_0002, 0, 0, 32'h0,       0, 32'h14,        1, NOP,           32'h8,         32'hC,         0, 3); // wait 2
    add(32'h10,        1, 32'hB000_0010, 0, 0, 32'h0,       1, 32'h14,        1, 32'hB000_0010, 32'h10,        32'h14,        1, 4);
    add(32'h14,        1, 32'hC000_0014, 0, 0, 32'h0,       1, 32'h18,        1, 32'hC000_0014, 32'h14,        32'h18,        1, 5);
    add(32'h20,        1, 32'hD000_0020, 1, 0, 32'h0,       0, 32'h24,        1, 32'hC000_0014, 32'h14,        32'h18,        1, 5); // capture
    add(32'h20,        1, 32'hBAD0_0003, 1, 0, 32'h0,       0, 32'h24,        0, 32'hC000_0014, 32'h14,        32'h18,        1, 5); // HOLD
    add(32'h20,        1, 32'hBAD0_0004, 1, 0, 32'h0,       0, 32'h24,        0, 32'hC000_0014, 32'h14,        32'h18,        1, 5); // HOLD
    add(32'h20,        1, 32'hBAD0_0005, 0, 0, 32'h0,       1, 32'h24,        0, 32'hD000_0020, 32'h20,        32'h24,        1, 6); // release
    add(32'h24,        1, 32'hE000_0024, 1, 0, 32'h0,       0, 32'h28,        1, 32'hD000_0020, 32'h20,        32'h24,        1, 6); // capture
    add(32'h24,        1, 32'hBAD0_0006, 1, 1, 32'h100,     1, 32'h100,       0, NOP,           32'h20,        32'h24,        0, 6); // redirect in HOLD
    add(32'h100,       1, 32'hF000_0100, 0, 0, 32'h0,       1, 32'h104,       1, 32'hF000_0100, 32'h100,       32'h104,       1, 7);
    add(32'h104,       1, 32'hBAD0_0007, 0, 1, 32'h200,     1, 32'h200,       1, NOP,           32'h100,       32'h104,       0, 7); // redirect in FETCH
    add(32'hFFFF_FFFC, 1, 32'h1234_5678, 0, 0, 32'h0,       1, 32'h0,         1, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0,         1, 8); // wrap
    add(32'h0,         0, 32'hBAD0_0008, 1, 0, 32'h0,       0, 32'h4,         1, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0,         1, 8); // wait+stall hold
    add(32'h0,         0, 32'hBAD0_0009, 0, 0, 32'h0,       0, 32'h4,         1, NOP,           32'hFFFF_FFFC, 32'h0,         0, 8); // bubble

    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    #12;
    chk("rst req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst en", {31'd0, en}, 32'd0);
    chk("rst PCNext", PCNext, 32'h0);
    chk_regs("rst", NOP, 32'h0, 32'h0, 1'b0, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("v%0d", k);
      drive(vecs[k].pc, vecs[k].rdy, vecs[k].rdata, vecs[k].stall, vecs[k].src, vecs[k].tgt);
      #1;
      chk({tag, " en"}, {31'd0, en}, {31'd0, vecs[k].e_en});
      chk({tag, " PCNext"}, PCNext, vecs[k].e_pcn);
      chk({tag, " req"}, {31'd0, imem.imem_req}, {31'd0, vecs[k].e_req});
      chk({tag, " addr"}, imem.imem_addr, vecs[k].pc);
      @(posedge clk); #1;
      chk_regs(tag, vecs[k].e_instr, vecs[k].e_pcd, vecs[k].e_p4, vecs[k].e_v, vecs[k].e_cnt);
      @(negedge clk);
    end

    // Reset pulse in the middle of a wait cycle: clears immediately
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    chk_regs("midrst", NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("midrst req", {31'd0, imem.imem_req}, 32'd0);
    chk("midrst PCNext", PCNext, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(32'h0, 1'b1, 32'h5555_0000, 1'b0, 1'b0, 32'h0);
    #1;
    chk("boot req", {31'd0, imem.imem_req}, 32'd0);
    chk("boot en", {31'd0, en}, 32'd0);
    @(posedge clk); #1;
    chk_regs("boot", NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    chk("refetch req", {31'd0, imem.imem_req}, 32'd1);
    @(posedge clk); #1;
    chk_regs("refetch", 32'h5555_0000, 32'h0, 32'h4, 1'b1, 32'd1);

    // Reset pulse while parked in HOLD: skid contents must be lost
    @(negedge clk);
    drive(32'h4, 1'b1, 32'h6666_0004, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_regs("holdrst", NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;  // BOOT -> FETCH
    @(negedge clk);
    #1;
    chk("postrst req", {31'd0, imem.imem_req}, 32'd1);
    @(posedge clk); #1;  // wait cycle in FETCH: bubble, no skid delivery
    chk_regs("postrst", NOP, 32'h0, 32'h0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1);
  end
endmodule
